// File: rtl/operand_sel_pipe.sv
// operand_sel_pipe: selects a register source or extended immediate into a two-entry skid-buffered output stage
module operand_sel_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int IMM_W  = 16,
    localparam int SW    = ($clog2(NUM_IN) < 1) ? 1 : $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SW-1:0]           sel,
    input  logic [NUM_IN*WIDTH-1:0] din,
    input  logic [IMM_W-1:0]        imm,
    input  logic                    imm_en,
    input  logic                    sext,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        operand_b,
    output logic                    sel_err
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] din_sel, imm_ext, new_val, skid_val;
    logic new_err, skid_err, sel_oob, push, pop, load_main, load_skid, skid_to_main;
    always_comb begin
        din_sel = '0;
        for (int k = 0; k < NUM_IN; k++) din_sel = (sel == SW'(k)) ? din[k*WIDTH +: WIDTH] : din_sel;
    end
    assign imm_ext = sext ? WIDTH'($signed(imm)) : WIDTH'(imm);
    // out-of-range sel never matches a source above, so din_sel is already zero for it
    assign sel_oob = {1'b0, sel} >= (SW+1)'(NUM_IN);
    assign new_val = imm_en ? imm_ext : din_sel;
    assign new_err = !imm_en && sel_oob;
    assign push = in_valid && in_ready;
    assign pop = out_valid && out_ready;
    assign out_valid = state != EMPTY;
    always_comb begin
        state_n = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        skid_to_main = 1'b0;
        unique case (state)
            EMPTY: begin
                state_n = push ? ONE : EMPTY;
                load_main = push;
            end
            ONE: begin
                state_n = (push && !pop) ? FULL : (!push && pop) ? EMPTY : ONE;
                load_main = push && pop;
                load_skid = push && !pop;
            end
            FULL: begin
                state_n = pop ? ONE : FULL;
                skid_to_main = pop;
            end
            default: state_n = EMPTY;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            in_ready <= 1'b1;
            operand_b <= '0;
            sel_err <= 1'b0;
            skid_val <= '0;
            skid_err <= 1'b0;
        end else begin
            state <= state_n;
            in_ready <= state_n != FULL;
            operand_b <= load_main ? new_val : skid_to_main ? skid_val : operand_b;
            sel_err <= load_main ? new_err : skid_to_main ? skid_err : sel_err;
            skid_val <= load_skid ? new_val : skid_val;
            skid_err <= load_skid ? new_err : skid_err;
        end
    end
endmodule

// File: tb/tb_operand_sel_pipe.sv
// tb_operand_sel_pipe: random and directed scoreboard bench driving a 4-source and a 3-source instance in lockstep
module tb_operand_sel_pipe;
    typedef logic [32:0] ent_t;
    logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, imm_en = 0, sext = 0;
    logic [1:0] sel = 0;
    logic [15:0] imm = 0;
    logic [127:0] din = 0;
    logic in_ready4, out_valid4, sel_err4, in_ready3, out_valid3, sel_err3;
    logic [31:0] operand_b4, operand_b3;
    ent_t q4[$], q3[$];
    int checks = 0, errors = 0, cyc = 0;
    bit post_rst = 0;

    always #5 clk = ~clk;

    operand_sel_pipe #(.WIDTH(32), .NUM_IN(4), .IMM_W(16)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .sel(sel),
        .din(din), .imm(imm), .imm_en(imm_en), .sext(sext), .out_valid(out_valid4),
        .out_ready(out_ready), .operand_b(operand_b4), .sel_err(sel_err4));
    operand_sel_pipe #(.WIDTH(32), .NUM_IN(3), .IMM_W(16)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .sel(sel),
        .din(din[95:0]), .imm(imm), .imm_en(imm_en), .sext(sext), .out_valid(out_valid3),
        .out_ready(out_ready), .operand_b(operand_b3), .sel_err(sel_err3));

    function automatic ent_t model(int n, int s, logic [15:0] i, logic ie, logic se, logic [127:0] d);
        if (ie) return {1'b0, (se && i[15]) ? 16'hFFFF : 16'h0000, i};
        if (s < n) return {1'b0, d[s*32 +: 32]};
        return {1'b1, 32'h0};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        post_rst = rst;
        if (rst) begin
            q4.delete();
            q3.delete();
        end else begin
            if (out_valid4 && out_ready && q4.size() > 0) void'(q4.pop_front());
            if (out_valid3 && out_ready && q3.size() > 0) void'(q3.pop_front());
            if (in_valid && in_ready4) q4.push_back(model(4, sel, imm, imm_en, sext, din));
            if (in_valid && in_ready3) q3.push_back(model(3, sel, imm, imm_en, sext, din));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (post_rst) begin
                chk("rst_out_valid4", 32'(out_valid4), 0);
                chk("rst_in_ready4", 32'(in_ready4), 1);
                chk("rst_operand4", operand_b4, 0);
                chk("rst_sel_err4", 32'(sel_err4), 0);
                chk("rst_out_valid3", 32'(out_valid3), 0);
                chk("rst_in_ready3", 32'(in_ready3), 1);
                chk("rst_operand3", operand_b3, 0);
                chk("rst_sel_err3", 32'(sel_err3), 0);
            end
            chk("in_ready4", 32'(in_ready4), 32'(q4.size() < 2));
            chk("out_valid4", 32'(out_valid4), 32'(q4.size() > 0));
            if (out_valid4 && q4.size() > 0) begin
                chk("operand4", operand_b4, q4[0][31:0]);
                chk("sel_err4", 32'(sel_err4), 32'(q4[0][32]));
            end
            chk("in_ready3", 32'(in_ready3), 32'(q3.size() < 2));
            chk("out_valid3", 32'(out_valid3), 32'(q3.size() > 0));
            if (out_valid3 && q3.size() > 0) begin
                chk("operand3", operand_b3, q3[0][31:0]);
                chk("sel_err3", 32'(sel_err3), 32'(q3[0][32]));
            end
        end
    end

    task automatic issue(input logic [1:0] s, input logic [15:0] i, input logic ie, input logic se,
                         input logic [127:0] d);
        bit ok;
        int n = 0;
        in_valid = 1;
        sel = s;
        imm = i;
        imm_en = ie;
        sext = se;
        din = d;
        do begin
            ok = in_ready4;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready stayed %b for %0d cycles, required 1", in_ready4, n);
        end
        in_valid = 0;
    endtask

    function automatic logic [127:0] rdin();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic rissue();
        issue(2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdin());
    endtask

    initial begin
        int c0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        out_ready = 1;
        issue(2, 16'h0, 0, 0, {32'h11111111, 32'hDEADBEEF, 32'h22222222, 32'h33333333});
        issue(0, 16'h8001, 1, 1, rdin());
        issue(1, 16'h8001, 1, 0, rdin());
        issue(3, 16'h0, 0, 0, rdin());
        repeat (2) @(posedge clk);
        #1 out_ready = 0;
        rissue();
        rissue();
        fork
            rissue();
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        repeat (3) @(posedge clk);
        #1 c0 = cyc;
        for (int r = 0; r < 100; r++) rissue();
        chk("throughput_cycles", 32'(cyc - c0), 100);
        fork
            for (int r = 0; r < 60; r++) rissue();
            for (int r = 0; r < 200; r++) begin
                @(posedge clk);
                #1 out_ready = 1'($urandom_range(0, 1));
            end
        join
        out_ready = 1;
        repeat (4) @(posedge clk);
        #1 out_ready = 0;
        rissue();
        rissue();
        in_valid = 1;
        sel = 1;
        imm_en = 0;
        din = rdin();
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1 out_ready = 1;
        rissue();
        rissue();
        repeat (4) @(posedge clk);
        #1 $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_sel_pipe.md
OPERAND_SEL_PIPE -- requirements
Module: operand_sel_pipe

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand width in bits.
REQ-002 Parameter NUM_IN, default 4, range 2..16, SHALL set the number of register-source data inputs.
REQ-003 Parameter IMM_W, default 16, range 1..WIDTH, SHALL set the immediate field width; SW = max(1, clog2(NUM_IN)).
REQ-004 Ports SHALL be, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream operand request valid.
- in_ready  out  1  block can accept a request.
- sel  in  SW  source index into din.
- din  in  NUM_IN*WIDTH  packed sources; source k = din[k*WIDTH +: WIDTH].
- imm  in  IMM_W  immediate field.
- imm_en  in  1  1 = use extended imm instead of din[sel].
- sext  in  1  1 = sign-extend imm, 0 = zero-extend.
- out_valid  out  1  operand_b holds a valid result.
- out_ready  in  1  downstream accepts the result.
- operand_b  out  WIDTH  selected operand.
- sel_err  out  1  result was produced from an out-of-range sel.
REQ-005 Reset SHALL be synchronous and active-high on rst; there is one clock, clk.

Function
REQ-006 Request accepted ("push") SHALL mean in_valid & in_ready at a rising edge; result consumed ("pop") SHALL mean out_valid & out_ready.
REQ-007 Selected value SHALL be: imm_en=1 -> imm extended to WIDTH (sext=1 replicates imm[IMM_W-1], sext=0 fills zeros); imm_en=0 and sel<NUM_IN -> din[sel]; imm_en=0 and sel>=NUM_IN -> all zeros.
REQ-008 sel_err SHALL be captured with the result and be 1 only for imm_en=0 and sel>=NUM_IN; imm_en=1 SHALL ignore sel.
REQ-009 The block SHALL hold two entries, main and skid, and run the state machine EMPTY, ONE, FULL.
REQ-010 EMPTY: push -> ONE (load main); no push -> EMPTY.
REQ-011 ONE: push without pop -> FULL (load skid); push with pop -> ONE (main reloaded from input); pop without push -> EMPTY; neither -> ONE.
REQ-012 FULL: pop -> ONE (skid moves to main); no pop -> FULL; no push possible.
REQ-013 in_ready SHALL be a registered output equal to (state != FULL); it SHALL NOT depend combinationally on out_ready.
REQ-014 out_valid SHALL equal (state != EMPTY); operand_b and sel_err SHALL always come from the main entry.
REQ-015 Latency SHALL be 1 cycle: a push into EMPTY at edge N gives out_valid=1 with the value after edge N.
REQ-016 Results SHALL leave in acceptance order; none lost, duplicated, or reordered.
REQ-017 While out_valid=1 and out_ready=0, operand_b and sel_err SHALL stay stable.
REQ-018 din, sel, imm, imm_en, sext SHALL be sampled only at the push edge; later changes SHALL NOT affect stored entries.
REQ-019 With out_ready held 1, the block SHALL sustain one push and one pop per cycle, staying in ONE.

Reset
REQ-020 rst=1 at an edge SHALL force EMPTY, out_valid=0, in_ready=1, operand_b=0, sel_err=0, discarding both entries.
REQ-021 rst SHALL override any same-edge push or pop; the first push can occur on the first edge with rst=0.

Verification
REQ-022 The bench SHALL cover these scenarios:
- WIDTH=32, NUM_IN=4: push sel=2, din[2]=0xDEADBEEF, imm_en=0, out_ready=1 -> next cycle out_valid=1, operand_b=0xDEADBEEF, sel_err=0.
- IMM_W=16: push imm=0x8001, imm_en=1, sext=1 -> operand_b=0xFFFF8001; same with sext=0 -> 0x00008001.
- NUM_IN=3: push sel=3, imm_en=0 -> operand_b=0, sel_err=1.
- out_ready=0: push A, B -> in_ready=0 after second push, third request stalls; then out_ready=1 -> A, then B, then the third value, in order and stable while stalled.
- Continuous in_valid=1, out_ready=1 for 100 random requests -> one result per cycle, all match the reference model in order.
- Assert rst while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, operand_b=0; the dropped entries never appear.
